// File: rtl/mux_scan_ctrl_if.sv
// Frame handshake between the scan controller and its downstream consumer.
// The master presents frame/frame_valid; the slave answers with frame_ready.
interface mux_scan_ctrl_if;
    logic [3:0] frame;
    logic       frame_valid;
    logic       frame_ready;

    modport master (
        output frame,
        output frame_valid,
        input  frame_ready
    );

    modport slave (
        input  frame,
        input  frame_valid,
        output frame_ready
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 bit mux. Steps sel through channels 0..3, holding
// each for DWELL cycles and sampling the mux output on the last edge of each
// dwell. The four samples are packed into a frame offered downstream with a
// valid/ready handshake, either once per start or continuously.
module mux_scan_ctrl #(
    parameter int unsigned DWELL = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            cont,
    input  logic            y_in,
    output logic [1:0]      sel,
    output logic            busy,
    mux_scan_ctrl_if.master frm
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Terminal dwell count: the edge on which the counter equals this value
    // is the sample edge for the current channel.
    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    state_t     state;
    logic [7:0] dwell_cnt;
    logic [2:0] shadow;
    logic [3:0] frame_q;
    logic       valid_q;

    assign frm.frame       = frame_q;
    assign frm.frame_valid = valid_q;

    // Scan state machine: dwell timing, channel sampling, frame handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= '0;
            busy      <= 1'b0;
            dwell_cnt <= '0;
            shadow    <= '0;
            frame_q   <= '0;
            valid_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SCAN;
                        sel       <= '0;
                        busy      <= 1'b1;
                        dwell_cnt <= '0;
                    end
                end

                SCAN: begin
                    if (dwell_cnt == DWELL_LAST) begin
                        dwell_cnt <= '0;
                        if (sel == 2'd3) begin
                            // Channel 3 goes straight into the frame; the
                            // shadow only needs to hold channels 0..2.
                            frame_q <= {y_in, shadow};
                            valid_q <= 1'b1;
                            sel     <= '0;
                            state   <= HOLD;
                        end else begin
                            shadow[sel] <= y_in;
                            sel         <= sel + 2'd1;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + 8'd1;
                    end
                end

                HOLD: begin
                    if (frm.frame_ready) begin
                        valid_q   <= 1'b0;
                        dwell_cnt <= '0;
                        sel       <= '0;
                        if (cont) begin
                            state <= SCAN;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl. Three instances (DWELL = 2, 4, 1) each
// feed their own modelled 4:1 mux. Stimulus pushes expected frames and their
// valid-rise cycle into a scoreboard; a monitor pops and compares on each
// rising frame_valid.
module tb_mux_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    logic       rst_s   [3];
    logic       start_s [3];
    logic       cont_s  [3];
    logic       ready_s [3];
    logic [3:0] mux_in  [3];
    logic [1:0] sel_w   [3];
    logic       y_w     [3];
    logic       busy_w  [3];
    logic       valid_w [3];
    logic [3:0] frame_w [3];

    for (genvar g = 0; g < 3; g++) begin : gd
        mux_scan_ctrl_if ifc ();

        mux_scan_ctrl #(.DWELL(g == 0 ? 2 : (g == 1 ? 4 : 1))) dut (
            .clk   (clk),
            .rst   (rst_s[g]),
            .start (start_s[g]),
            .cont  (cont_s[g]),
            .y_in  (y_w[g]),
            .sel   (sel_w[g]),
            .busy  (busy_w[g]),
            .frm   (ifc)
        );

        assign ifc.frame_ready = ready_s[g];
        assign frame_w[g]      = ifc.frame;
        assign valid_w[g]      = ifc.frame_valid;
        assign y_w[g]          = mux_in[g][sel_w[g]];
    end

    typedef struct {
        int         d;
        logic [3:0] f;
        int         c;
    } exp_t;

    exp_t exp_q [$];
    exp_t mon_e;
    logic pv [3] = '{1'b0, 1'b0, 1'b0};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Land on the negedge that follows posedge number c.
    task automatic at_edge(input int unsigned c);
        @(negedge clk);
        while (cyc < c) @(negedge clk);
    endtask

    // Pulse start for one edge; returns just after that edge with its number.
    task automatic do_start(input int d, output int unsigned t);
        start_s[d] = 1'b1;
        @(posedge clk);
        #1;
        start_s[d] = 1'b0;
        t = cyc;
    endtask

    task automatic expect_frame(input int d, input logic [3:0] f, input int unsigned c);
        exp_q.push_back('{d, f, int'(c)});
    endtask

    // Monitor: every rising frame_valid must match the head of the scoreboard.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (valid_w[d] && !pv[d]) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid_dut", d, -1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("frame_dut", d, mon_e.d);
                    chk("frame", int'(frame_w[d]), int'(mon_e.f));
                    chk("valid_cycle", int'(cyc), mon_e.c);
                end
            end
            pv[d] = valid_w[d];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned t;

        for (int d = 0; d < 3; d++) begin
            rst_s[d]   = 1'b1;
            start_s[d] = 1'b0;
            cont_s[d]  = 1'b0;
            ready_s[d] = 1'b0;
            mux_in[d]  = 4'b0000;
        end
        // Drive start/cont high during reset: reset must win.
        start_s[0] = 1'b1;
        cont_s[0]  = 1'b1;
        at_edge(2);
        for (int d = 0; d < 3; d++) begin
            chk("rst_sel",   int'(sel_w[d]),   0);
            chk("rst_frame", int'(frame_w[d]), 0);
            chk("rst_valid", int'(valid_w[d]), 0);
            chk("rst_busy",  int'(busy_w[d]),  0);
            rst_s[d] = 1'b0;
        end
        start_s[0] = 1'b0;
        cont_s[0]  = 1'b0;

        // Single scan, DWELL=2, input 1010, ready high.
        mux_in[0]  = 4'b1010;
        ready_s[0] = 1'b1;
        at_edge(cyc + 1);
        do_start(0, t);
        expect_frame(0, 4'b1010, t + 8);
        for (int unsigned k = 0; k < 8; k++) begin
            at_edge(t + k);
            chk("scan_sel", int'(sel_w[0]), int'(k / 2));
        end
        at_edge(t + 9);
        chk("accept_valid", int'(valid_w[0]), 0);
        chk("accept_busy",  int'(busy_w[0]),  0);
        chk("accept_frame_kept", int'(frame_w[0]), 'b1010);

        // Backpressure: ready low for 5 cycles after valid.
        ready_s[0] = 1'b0;
        at_edge(cyc + 1);
        do_start(0, t);
        expect_frame(0, 4'b1010, t + 8);
        for (int unsigned k = 0; k < 5; k++) begin
            at_edge(t + 8 + k);
            chk("bp_valid", int'(valid_w[0]), 1);
            chk("bp_frame", int'(frame_w[0]), 'b1010);
            chk("bp_sel",   int'(sel_w[0]),   0);
            chk("bp_busy",  int'(busy_w[0]),  1);
        end
        ready_s[0] = 1'b1;
        at_edge(t + 13);
        chk("bp_accept_valid", int'(valid_w[0]), 0);
        chk("bp_accept_busy",  int'(busy_w[0]),  0);

        // Continuous: 0110, 1001, 0110 with valid pulses 9 cycles apart.
        mux_in[0] = 4'b0110;
        cont_s[0] = 1'b1;
        at_edge(cyc + 1);
        do_start(0, t);
        expect_frame(0, 4'b0110, t + 8);
        expect_frame(0, 4'b1001, t + 17);
        expect_frame(0, 4'b0110, t + 26);
        at_edge(t + 3);
        start_s[0] = 1'b1;
        at_edge(t + 4);
        start_s[0] = 1'b0;
        at_edge(t + 9);
        chk("cont_busy", int'(busy_w[0]), 1);
        chk("cont_sel_restart", int'(sel_w[0]), 0);
        chk("cont_frame_stable", int'(frame_w[0]), 'b0110);
        mux_in[0] = 4'b1001;
        at_edge(t + 12);
        start_s[0] = 1'b1;
        at_edge(t + 13);
        start_s[0] = 1'b0;
        at_edge(t + 18);
        mux_in[0] = 4'b0110;
        cont_s[0] = 1'b0;
        at_edge(t + 27);
        chk("cont_end_busy",  int'(busy_w[0]),  0);
        chk("cont_end_valid", int'(valid_w[0]), 0);

        // Mid-dwell change, DWELL=4: bit 1 rises during channel-1 dwell.
        ready_s[1] = 1'b1;
        mux_in[1]  = 4'b0000;
        at_edge(cyc + 1);
        do_start(1, t);
        expect_frame(1, 4'b0010, t + 16);
        at_edge(t + 5);
        mux_in[1] = 4'b0010;
        at_edge(t + 17);
        mux_in[1] = 4'b0000;
        at_edge(cyc + 1);
        do_start(1, t);
        expect_frame(1, 4'b0000, t + 16);
        at_edge(t + 8);
        mux_in[1] = 4'b0010;
        at_edge(t + 17);
        chk("late_change_busy", int'(busy_w[1]), 0);

        // Reset right after channel 1 is sampled aborts the scan.
        mux_in[0] = 4'b1010;
        at_edge(cyc + 1);
        do_start(0, t);
        at_edge(t + 4);
        rst_s[0] = 1'b1;
        at_edge(t + 5);
        rst_s[0] = 1'b0;
        chk("abort_sel",   int'(sel_w[0]),   0);
        chk("abort_frame", int'(frame_w[0]), 0);
        chk("abort_valid", int'(valid_w[0]), 0);
        chk("abort_busy",  int'(busy_w[0]),  0);
        at_edge(t + 15);
        do_start(0, t);
        expect_frame(0, 4'b1010, t + 8);
        at_edge(t + 9);
        chk("after_abort_busy", int'(busy_w[0]), 0);

        // DWELL=1: sel advances every cycle, valid 4 cycles after start.
        ready_s[2] = 1'b1;
        mux_in[2]  = 4'b1111;
        at_edge(cyc + 1);
        do_start(2, t);
        expect_frame(2, 4'b1111, t + 4);
        for (int unsigned k = 0; k < 4; k++) begin
            at_edge(t + k);
            chk("d1_sel", int'(sel_w[2]), int'(k));
        end
        at_edge(t + 5);
        mux_in[2] = 4'b0001;
        at_edge(cyc + 1);
        do_start(2, t);
        expect_frame(2, 4'b0001, t + 4);
        at_edge(t + 5);
        chk("d1_busy", int'(busy_w[2]), 0);

        at_edge(cyc + 3);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Sequencer that sits directly upstream of the 4:1 bit mux. It drives the mux select and consumes the mux output.
- It steps `sel` through channels 0..3, holding each channel for DWELL cycles, and samples the mux output at the end of each dwell.
- It packs the four samples into a 4-bit frame and presents the frame downstream with a valid/ready handshake.
- Net effect: the 4-bit mux input is reconstructed serially, one channel at a time.

Parameters:
- DWELL, 2, cycles `sel` is held per channel. Legal range 1..255. The internal dwell counter is 8 bits.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request one scan; sampled only in IDLE
- cont  input  1  continuous mode; sampled when a frame is accepted
- y_in  input  1  mux output (combinational function of sel)
- sel  output  2  mux select, registered
- frame  output  4  assembled frame; frame[k] = y_in sampled while sel==k
- frame_valid  output  1  frame available
- frame_ready  input  1  downstream accepts frame
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst high at an edge): state=IDLE, sel=0, frame=0, frame_valid=0, busy=0, dwell counter=0, channel index=0, shadow register=0. Reset overrides all other inputs. Reset mid-scan or in HOLD aborts; no partial frame is ever emitted.
- States: IDLE, SCAN, HOLD.
- IDLE -> SCAN: start=1 at edge t. From t: sel=0, busy=1, counter=0.
- SCAN, per edge:
  - Counter increments.
  - When the counter reaches DWELL-1 at an edge, y_in is written into shadow[sel], the counter clears, and sel increments.
  - Result: sel=k is visible for cycles t+k*DWELL .. t+(k+1)*DWELL-1. Channel k is sampled at edge t+(k+1)*DWELL.
  - The sample uses the y_in value present just before that edge. Changes of the mux input earlier in the dwell are not captured.
- SCAN -> HOLD: at edge t+4*DWELL (channel 3 sampled).
  - frame <= {y_in, shadow[2:0]}; frame_valid=1; sel returns to 0.
  - Scan latency is exactly 4*DWELL cycles from the start edge to frame_valid.
- HOLD:
  - frame and frame_valid are held stable until an edge with frame_ready=1. That edge is the acceptance.
  - On acceptance: frame_valid=0 and frame retains its value.
  - If cont=1 at acceptance: go to SCAN; sel=0 from that edge; the next frame_valid follows 4*DWELL cycles later.
  - If cont=0 at acceptance: go to IDLE; busy=0.
- frame_ready while frame_valid=0 has no effect.
- start while busy is ignored (not queued).
- frame only changes on the SCAN->HOLD transition or on reset. It is stable during the following scan.
- cont has no effect in IDLE or SCAN. Only start launches from IDLE.
- sel wraps only via the HOLD transition back to 0; it never exceeds 3.
- DWELL=1: sel advances every cycle, and frame_valid is asserted 4 cycles after start.

Test Plan:
- DWELL=2, mux input 4'b1010 static, start pulse at edge t, ready=1 -> sel sequence 0,0,1,1,2,2,3,3; frame_valid=1 after edge t+8 with frame=4'b1010; valid drops after edge t+9; busy=0 after edge t+9 (cont=0).
- Backpressure: ready=0 for 5 cycles after valid -> frame=4'b1010 and frame_valid=1 held; sel=0; busy=1; accepted on the first edge with ready=1.
- Continuous: cont=1, ready=1, mux input alternating 4'b0110 and 4'b1001 between scans -> frames 0110, 1001, 0110 delivered, with valid pulses spaced 4*DWELL+1 cycles apart; start pulses during the scans are ignored.
- Mid-dwell change: DWELL=4, i[1] goes 0->1 in the 2nd cycle of the channel-1 dwell -> frame[1]=1; the same change made after the channel-1 sample edge -> frame[1]=0.
- Reset mid-scan: rst=1 at the edge after channel 1 is sampled -> next cycle sel=0, frame=0, frame_valid=0, busy=0; no valid pulse follows; a new start completes normally.
- DWELL=1 with input 4'b1111 then 4'b0001 -> frame_valid 4 cycles after each start, with frames 1111 and 0001.
